ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter on the `ps2_clk`/`ps2_data` open-drain pair.
- Sends one command byte (e.g. 0xF4 enable-reporting, 0xFF reset) to the attached PS/2 device and reports ACK or failure.
- Sits beside the existing PS/2 receive path in `fractal_top`; `tx_busy` gates that receiver so it never decodes host-driven bits.
- Runs in the 50 MHz `clk` domain; the pad-level tristate lives in `fractal_top`.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_line_sync.sv | 36 +++
 rtl/ps2_host_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the receive path.
// Holds the transmitter state encoding, frame length and a time-to-cycles helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_IDLE
    } ps2_tx_st_t;

    // Start + 8 data + parity + stop.
    localparam int PS2_FRAME_BITS = 11;

    function automatic int unsigned us2cyc(input int unsigned us, input int unsigned freq);
        longint unsigned prod;
        prod = 64'(us) * 64'(freq) / 64'd1_000_000;
        return 32'(prod);
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a registered
// falling-edge pulse on the clock, landing three system cycles after the pad edge.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic fall
);

    logic clk_meta;
    logic data_meta;
    logic clk_prev;

    // Sync flops reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            fall      <= 1'b0;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
            fall      <= clk_prev & ~clk_sync;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional request/transfer watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
    parameter int unsigned INHIBIT_US      = 100,
    parameter int unsigned REQ_TIMEOUT_US  = 15_000,
    parameter int unsigned XFER_TIMEOUT_US = 2_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned INHIBIT_CYC = us2cyc(INHIBIT_US, CLK_FREQ_HZ);
    localparam int          INH_W       = $clog2(INHIBIT_CYC + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
    localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYC - 2);
    localparam logic [3:0]       BIT_SAT  = 4'(PS2_FRAME_BITS - 1);

    if (INHIBIT_CYC < 2 || REQ_TIMEOUT_US == 0 || XFER_TIMEOUT_US == 0) begin : g_cfg_check
        $error("ps2_host_tx: inhibit must span at least two cycles and timeouts must be non-zero");
    end

    ps2_tx_st_t       state, state_nxt;
    logic [8:0]       shreg, shreg_nxt;
    logic [3:0]       bitcnt, bitcnt_nxt;
    logic [INH_W-1:0] cnt, cnt_nxt;
    logic             clk_oe_nxt, data_oe_nxt, busy_nxt, done_nxt, err_nxt;

    logic clk_sync, data_sync, fall;
    logic dev_fall;

    ps2_line_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .clk_sync   (clk_sync),
        .data_sync  (data_sync),
        .fall       (fall)
    );

    // Edges seen while we hold the clock low are our own doing, not the device's.
    assign dev_fall = fall & ~ps2_clk_oe;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned REQ_CYC  = us2cyc(REQ_TIMEOUT_US, CLK_FREQ_HZ);
    localparam int unsigned XFER_CYC = us2cyc(XFER_TIMEOUT_US, CLK_FREQ_HZ);
    localparam int unsigned WD_MAX   = (REQ_CYC > XFER_CYC) ? REQ_CYC : XFER_CYC;
    localparam int          WD_W     = $clog2(WD_MAX + 1);
    localparam logic [WD_W-1:0] REQ_LAST  = WD_W'(REQ_CYC - 1);
    localparam logic [WD_W-1:0] XFER_LAST = WD_W'(XFER_CYC - 1);

    logic [WD_W-1:0] wd, wd_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd <= '0;
        end else begin
            wd <= wd_nxt;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            cnt         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            bitcnt      <= bitcnt_nxt;
            cnt         <= cnt_nxt;
            ps2_clk_oe  <= clk_oe_nxt;
            ps2_data_oe <= data_oe_nxt;
            tx_busy     <= busy_nxt;
            tx_done     <= done_nxt;
            tx_err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bitcnt_nxt  = bitcnt;
        cnt_nxt     = cnt;
        clk_oe_nxt  = ps2_clk_oe;
        data_oe_nxt = ps2_data_oe;
        busy_nxt    = tx_busy;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (tx_start) begin
                    shreg_nxt  = {~^tx_data, tx_data};
                    bitcnt_nxt = '0;
                    cnt_nxt    = '0;
                    busy_nxt   = 1'b1;
                    clk_oe_nxt = 1'b1;
                    state_nxt  = INHIBIT;
                end
            end
            INHIBIT: begin
                // Start bit goes low one cycle before the clock is let go.
                if (cnt == INH_LAST) begin
                    clk_oe_nxt = 1'b0;
                    state_nxt  = REQ;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == INH_PRE) begin
                        data_oe_nxt = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dev_fall) begin
                    data_oe_nxt = ~shreg[0];
                    bitcnt_nxt  = 4'd1;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (dev_fall) begin
                    if (bitcnt <= 4'd8) begin
                        data_oe_nxt = ~shreg[bitcnt];
                    end else begin
                        data_oe_nxt = 1'b0;
                        state_nxt   = ACK;
                    end
                    bitcnt_nxt = (bitcnt == BIT_SAT) ? bitcnt : bitcnt + 4'd1;
                end
            end
            ACK: begin
                if (dev_fall) begin
                    if (!data_sync) begin
                        state_nxt = WAIT_IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Separate budgets: waiting for the device to start, then the whole frame.
        wd_nxt = '0;
        if (state == REQ || state == DATA || state == ACK || state == WAIT_IDLE) begin
            if ((state == REQ && wd == REQ_LAST) || (state != REQ && wd == XFER_LAST)) begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                done_nxt    = 1'b0;
                err_nxt     = 1'b1;
                busy_nxt    = 1'b0;
                state_nxt   = IDLE;
            end else if (state == REQ && state_nxt == DATA) begin
                wd_nxt = '0;
            end else begin
                wd_nxt = wd + 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of the host
// while a per-cycle model checks busy/line-drive timing. Honours PS2_HOST_TX_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int HALF           = 100;
    localparam int INHIBIT_CYCLES = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err;
    logic       clk_line, data_line;

    logic       s_rst = 1'b1;
    logic       s_tx_start = 1'b0;
    logic [7:0] s_tx_data = 8'h00;
    logic       s_clk_oe, s_data_oe, s_tx_busy, s_tx_done, s_tx_err;
    logic       s_clk_line, s_data_line;
    logic       slow_finished = 1'b0;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int err_count = 0;

    logic m_busy = 1'b0;
    int   m_age = 0;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host and device pull-downs.
    assign clk_line    = ~ps2_clk_oe & ~dev_clk_low;
    assign data_line   = ~ps2_data_oe & ~dev_data_low;
    assign s_clk_line  = ~s_clk_oe;
    assign s_data_line = ~s_data_oe;

    ps2_host_tx dut (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .ps2_clk_in (clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    // A 1 MHz-scaled instance with a silent device: 1 cycle per microsecond.
    ps2_host_tx #(.CLK_FREQ_HZ(1_000_000)) dut_slow (
        .clk        (clk),
        .rst        (s_rst),
        .tx_start   (s_tx_start),
        .tx_data    (s_tx_data),
        .ps2_clk_in (s_clk_line),
        .ps2_data_in(s_data_line),
        .ps2_clk_oe (s_clk_oe),
        .ps2_data_oe(s_data_oe),
        .tx_busy    (s_tx_busy),
        .tx_done    (s_tx_done),
        .tx_err     (s_tx_err)
    );

    function automatic logic [10:0] frameOf(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Transaction model: busy from an accepted start until the result pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_age  <= 0;
        end else if (!m_busy) begin
            if (tx_start) begin
                m_busy <= 1'b1;
                m_age  <= 1;
            end
        end else begin
            m_age <= m_age + 1;
            if (tx_done || tx_err) m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic exp_busy;
        if (!rst) begin
            exp_busy = m_busy && !(tx_done || tx_err);
            checkOutput("busy", tx_busy, exp_busy);
            checkOutput("pulse_exclusive", tx_done & tx_err, 0);
            if (!exp_busy) begin
                checkOutput("clk_oe_idle", ps2_clk_oe, 0);
                checkOutput("data_oe_idle", ps2_data_oe, 0);
            end else if (m_age <= INHIBIT_CYCLES) begin
                checkOutput("clk_oe_inhibit", ps2_clk_oe, 1);
                checkOutput("data_oe_inhibit", ps2_data_oe, (m_age >= INHIBIT_CYCLES) ? 1 : 0);
            end else if (m_age == INHIBIT_CYCLES + 1) begin
                checkOutput("clk_oe_release", ps2_clk_oe, 0);
                checkOutput("data_oe_start", ps2_data_oe, 1);
            end else begin
                checkOutput("clk_oe_xfer", ps2_clk_oe, 0);
            end
            if (!m_busy) begin
                checkOutput("done_idle", tx_done, 0);
                checkOutput("err_idle", tx_err, 0);
            end
            done_count += int'(tx_done);
            err_count  += int'(tx_err);
        end
    end

    task automatic deviceRun(input bit ack, input bit inject, output logic [10:0] frame, output int low_cycles);
        int guard;
        frame = '0;
        low_cycles = 0;
        guard = 0;
        while (clk_line && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (clk_line) begin
            checkOutput("inhibit_seen", clk_line, 0);
            return;
        end
        guard = 0;
        while (!clk_line && guard < 20000) begin
            low_cycles++;
            @(negedge clk);
            guard++;
        end
        checkOutput("rts_data_low", data_line, 0);
        frame[0] = data_line;
        repeat (20) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            frame[k] = data_line;
            dev_clk_low = 1'b0;
            if (inject && k == 4) begin
                tx_data  = 8'hAA;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        if (ack) dev_data_low = 1'b1;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit ack, input bit inject, output logic [10:0] frame);
        int d0, e0, low, guard;
        d0 = done_count;
        e0 = err_count;
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = ~b;
        deviceRun(ack, inject, frame, low);
        guard = 0;
        while (done_count == d0 && err_count == e0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (20) @(negedge clk);
        checkOutput("inhibit_cycles", low, INHIBIT_CYCLES);
        checkOutput("frame", 32'(frame), 32'(frameOf(b)));
        checkOutput("done_pulses", done_count - d0, ack ? 1 : 0);
        checkOutput("err_pulses", err_count - e0, ack ? 0 : 1);
        checkOutput("busy_after", tx_busy, 0);
    endtask

    initial begin
        logic [10:0] frame;
        int guard;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rst_clk_oe", ps2_clk_oe, 0);
        checkOutput("rst_data_oe", ps2_data_oe, 0);
        checkOutput("rst_busy", tx_busy, 0);
        checkOutput("rst_done", tx_done, 0);
        checkOutput("rst_err", tx_err, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] send 0xF4");
        applyStimulus(8'hF4, 1'b1, 1'b0, frame);
        checkOutput("frame_f4_literal", 32'(frame), 32'(11'b101_1110_1000));

        $display("[TB] send 0x00");
        applyStimulus(8'h00, 1'b1, 1'b0, frame);
        checkOutput("frame_00_literal", 32'(frame), 32'(11'b110_0000_0000));

        $display("[TB] send 0x5A with NACK");
        applyStimulus(8'h5A, 1'b0, 1'b0, frame);

        $display("[TB] send 0xF4 with 0xAA start during DATA");
        applyStimulus(8'hF4, 1'b1, 1'b1, frame);
        checkOutput("frame_busy_ignore", 32'(frame), 32'(11'b101_1110_1000));

        $display("[TB] reset during DATA");
        @(negedge clk);
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        guard = 0;
        while (!clk_line && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("data_oe_before_rst", ps2_data_oe, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_clk_oe", ps2_clk_oe, 0);
        checkOutput("rst_mid_data_oe", ps2_data_oe, 0);
        checkOutput("rst_mid_busy", tx_busy, 0);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] send 0xFF after reset");
        applyStimulus(8'hFF, 1'b1, 1'b0, frame);
        checkOutput("frame_ff_literal", 32'(frame), 32'(11'b111_1111_1110));

        guard = 0;
        while (!slow_finished && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("slow_finished", slow_finished, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Silent-device scenario on the scaled instance.
    initial begin
        int guard;
        int n;
        s_rst = 1'b1;
        repeat (5) @(negedge clk);
        s_rst = 1'b0;
        @(negedge clk);
        s_tx_data  = 8'hF4;
        s_tx_start = 1'b1;
        @(negedge clk);
        s_tx_start = 1'b0;
        guard = 0;
        while (s_clk_oe && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("slow_released", s_clk_oe, 0);
        n = 0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        while (!s_tx_err && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("slow_timeout_cycles", n, 15000);
        checkOutput("slow_timeout_busy", s_tx_busy, 0);
        checkOutput("slow_timeout_clk_oe", s_clk_oe, 0);
        checkOutput("slow_timeout_data_oe", s_data_oe, 0);
`else
        while (s_tx_busy && !s_tx_err && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("slow_busy_held", n, 20000);
        checkOutput("slow_no_err", s_tx_err, 0);
`endif
        slow_finished = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
